sp_fifo_ctl_1024x16: RTL

SP_FIFO_CTL_1024X16 -- requirements
Module: sp_fifo_ctl_1024x16

---
 rtl/sp_fifo_ctl_1024x16_pkg.sv | 21 ++
 rtl/sp_fifo_ctl_1024x16_if.sv | 12 +
 rtl/sp_fifo_ctl_1024x16_obuf.sv | 51 +++++
 rtl/sp_fifo_ctl_1024x16.sv | 112 +++++++++++
 4 files changed

// File: rtl/sp_fifo_ctl_1024x16_pkg.sv
// Shared constants and memory-operation encoding for the 1024x16 single-port FIFO controller.
package sp_fifo_ctl_1024x16_pkg;

  localparam int FIFO_DEPTH = 1024;
  localparam int DATA_W     = 16;
  localparam int ADR_W      = 10;
  localparam int CNT_W      = 11;
  localparam int OBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_READ  = 2'd2
  } mem_op_e;

  // Writes always update both bytes; reads and idle cycles leave enables low.
  function automatic logic [1:0] mem_wen(input mem_op_e op);
    return (op == MEM_WRITE) ? 2'b11 : 2'b00;
  endfunction

endpackage

// File: rtl/sp_fifo_ctl_1024x16_if.sv
// Valid/ready word stream used for the push and pop sides of the FIFO.
interface sp_fifo_ctl_1024x16_if;
  import sp_fifo_ctl_1024x16_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/sp_fifo_ctl_1024x16_obuf.sv
// Two-entry output buffer absorbing RAM read latency; entry 0 is always the head word.
module sp_fifo_obuf
  import sp_fifo_ctl_1024x16_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cap_valid_i,
  input  logic [DATA_W-1:0]             cap_data_i,
  output logic [1:0]                    cnt_o,
  sp_fifo_ctl_1024x16_if.master         pop
);

  logic [DATA_W-1:0] ent_q [OBUF_DEPTH];
  logic [DATA_W-1:0] ent_d [OBUF_DEPTH];
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              pop_fire;

  assign pop.valid = rst_n && (cnt_q != 2'd0);
  assign pop.data  = ent_q[0];
  assign pop_fire  = pop.valid && pop.ready;
  assign cnt_o     = cnt_q;

  // Pop shifts first, then the captured word lands in the first free slot,
  // so a simultaneous capture and pop keeps the count and the order intact.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (pop_fire) begin
      ent_d[0] = ent_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (cap_valid_i) begin
      ent_d[cnt_d[0]] = cap_data_i;
      cnt_d           = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/sp_fifo_ctl_1024x16.sv
// FIFO controller for an external 1024x16 single-port RAM with a two-word output buffer.
module sp_fifo_ctl_1024x16
  import sp_fifo_ctl_1024x16_pkg::*;
#(
  parameter int AF_THR = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push_valid,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_push_ready,
  output logic              o_pop_valid,
  output logic [DATA_W-1:0] o_pop_data,
  input  logic              i_pop_ready,
  output logic              o_mem_en,
  output logic [1:0]        o_mem_wen,
  output logic [ADR_W-1:0]  o_mem_adr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_almost_full
);

  logic [ADR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_pend_q, rd_pend_d;
  logic             prio_rd_q, prio_rd_d;
  logic             almost_full_q, almost_full_d;
  logic [1:0]       obuf_cnt;
  logic             rd_req, push_ready, push_fire, read_fire, pop_fire;
  mem_op_e          mem_op;

  sp_fifo_ctl_1024x16_if pop_bus ();

  sp_fifo_obuf u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_valid_i (rd_pend_q),
    .cap_data_i  (i_mem_rdata),
    .cnt_o       (obuf_cnt),
    .pop         (pop_bus)
  );

  assign pop_bus.ready = i_pop_ready;
  assign o_pop_valid   = pop_bus.valid;
  assign o_pop_data    = pop_bus.data;

  // Reads are requested only when the buffer can take the word without
  // backpressure; prio_rd hands the port to a waiting read after one push.
  always_comb begin
    rd_req     = rst_n && (mem_cnt_q != '0) &&
                 (({1'b0, obuf_cnt} + {2'b00, rd_pend_q}) < 3'd2);
    push_ready = rst_n && (mem_cnt_q < CNT_W'(FIFO_DEPTH)) && !(rd_req && prio_rd_q);
    push_fire  = i_push_valid && push_ready;
    read_fire  = rd_req && !push_fire;
    pop_fire   = o_pop_valid && i_pop_ready;

    mem_op = MEM_IDLE;
    if (push_fire) begin
      mem_op = MEM_WRITE;
    end else if (read_fire) begin
      mem_op = MEM_READ;
    end

    wr_ptr_d  = wr_ptr_q + ADR_W'(push_fire);
    rd_ptr_d  = rd_ptr_q + ADR_W'(read_fire);
    mem_cnt_d = mem_cnt_q + CNT_W'(push_fire) - CNT_W'(read_fire);
    rd_pend_d = read_fire;

    prio_rd_d = prio_rd_q;
    if (read_fire) begin
      prio_rd_d = 1'b0;
    end else if (push_fire && rd_req) begin
      prio_rd_d = 1'b1;
    end

    // Total occupancy only changes at the edges of the pipe: push in, pop out.
    count_d       = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    almost_full_d = (count_d >= CNT_W'(AF_THR));
  end

  assign o_push_ready  = push_ready;
  assign o_mem_en      = (mem_op != MEM_IDLE);
  assign o_mem_wen     = mem_wen(mem_op);
  assign o_mem_adr     = (mem_op == MEM_WRITE) ? wr_ptr_q : rd_ptr_q;
  assign o_mem_wdata   = i_push_data;
  assign o_count       = count_q;
  assign o_almost_full = almost_full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      count_q       <= '0;
      rd_pend_q     <= 1'b0;
      prio_rd_q     <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      count_q       <= count_d;
      rd_pend_q     <= rd_pend_d;
      prio_rd_q     <= prio_rd_d;
      almost_full_q <= almost_full_d;
    end
  end

endmodule
